mux_tree_pipe: RTL and testbench

- Parametrised, pipelined N-channel to 1 data multiplexer with a valid qualifier.
- Built as a binary tree of 2:1 mux levels, with one register stage per tree level.
- Two selection modes: external select, or an internal round-robin channel scan.
- Successor to the fixed 8:1 single-bit combinational mux. Used where wide buses from many channels are funnelled into one datapath at full clock rate.

---
 rtl/mux_pkg.sv | 22 ++
 rtl/mux_stage.sv | 25 ++
 rtl/mux_tree_pipe.sv | 112 +++++++++++
 tb/tb_mux_tree_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared helpers for the pipelined mux tree: width derivation and channel slicing.
// Macros are global so every file compiled after this one can size ports with them.
`ifndef MUX_PKG_SV
`define MUX_PKG_SV

`define MUX_SW(n) (mux_pkg::clog2(n))
`define MUX_L(n) (mux_pkg::clog2(n))
`define MUX_SLICE(bus, k, w) bus[(k)*(w) +: (w)]

package mux_pkg;

  // ceil(log2(n)); callers guarantee n >= 2, so the result is at least 1
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

`endif

// File: rtl/mux_stage.sv
// One registered level of the mux tree: N_PAIR 2:1 muxes sharing a single select bit.
module mux_stage
  import mux_pkg::*;
#(
  parameter int N_PAIR = 4,
  parameter int W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic [2*N_PAIR*W-1:0] in_data,
  output logic [N_PAIR*W-1:0]   out_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else begin
      for (int i = 0; i < N_PAIR; i++)
        `MUX_SLICE(out_data, i, W) <= sel ? `MUX_SLICE(in_data, 2*i+1, W)
                                          : `MUX_SLICE(in_data, 2*i, W);
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// N_CH:1 pipelined mux tree, one register per level, with external or round-robin select.
// Each sample carries its own select index, valid and error flag down the pipe.
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int  N_CH = 8,
  parameter int  W    = 8,
  localparam int SW   = `MUX_SW(N_CH),
  localparam int L    = `MUX_L(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic              in_valid,
  input  logic [SW-1:0]     sel,
  input  logic              scan_en,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic [SW-1:0]     out_ch,
  output logic              out_err
);

  localparam int P = 1 << L;

  // Missing leaves are zero; any index >= N_CH lands on one of them, which
  // is what drives out_data to 0 for out-of-range selects.
  logic [P*W-1:0] leaves;
  always_comb begin
    leaves = '0;
    leaves[N_CH*W-1:0] = in_data;
  end

  logic [SW-1:0] scan_cnt;
  logic [SW-1:0] cnt_now;
  logic [SW-1:0] eff_sel;
  logic          scan_en_d;
  logic          sel_err;

  // A fresh scan run always starts at channel 0.
  assign cnt_now = (scan_en && !scan_en_d) ? '0 : scan_cnt;
  assign eff_sel = scan_en ? cnt_now : sel;
  assign sel_err = (int'(eff_sel) >= N_CH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_en_d <= 1'b0;
    end else begin
      scan_en_d <= scan_en;
      if (scan_en) begin
        if (in_valid)
          scan_cnt <= (cnt_now == SW'(N_CH - 1)) ? '0 : cnt_now + SW'(1);
        else
          scan_cnt <= cnt_now;
      end
    end
  end

  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int NP = P >> (j + 1);

    logic [2*NP*W-1:0] d_in;
    logic [NP*W-1:0]   d_out;
    logic [SW-1:0]     i_in;
    logic [SW-1:0]     idx;
    logic              v_in;
    logic              vld;
    logic              e_in;
    logic              err;

    if (j == 0) begin : g_head
      assign d_in = leaves;
      assign i_in = eff_sel;
      assign v_in = in_valid;
      assign e_in = sel_err;
    end else begin : g_body
      assign d_in = g_lvl[j-1].d_out;
      assign i_in = g_lvl[j-1].idx;
      assign v_in = g_lvl[j-1].vld;
      assign e_in = g_lvl[j-1].err;
    end

    mux_stage #(
      .N_PAIR (NP),
      .W      (W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .sel      (i_in[j]),
      .in_data  (d_in),
      .out_data (d_out)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld <= 1'b0;
        idx <= '0;
        err <= 1'b0;
      end else begin
        vld <= v_in;
        idx <= i_in;
        err <= e_in;
      end
    end
  end

  assign out_data  = g_lvl[L-1].d_out;
  assign out_valid = g_lvl[L-1].vld;
  assign out_ch    = g_lvl[L-1].idx;
  assign out_err   = g_lvl[L-1].err;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: an 8-channel and a 5-channel instance side by side.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst;

  logic [63:0] a_in_data;
  logic        a_in_valid;
  logic [2:0]  a_sel;
  logic        a_scan_en;
  logic [7:0]  a_out_data;
  logic        a_out_valid;
  logic [2:0]  a_out_ch;
  logic        a_out_err;

  logic [39:0] b_in_data;
  logic        b_in_valid;
  logic [2:0]  b_sel;
  logic        b_scan_en;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic [2:0]  b_out_ch;
  logic        b_out_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_tree_pipe #(.N_CH(8), .W(8)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .sel(a_sel),
    .scan_en(a_scan_en), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ch(a_out_ch), .out_err(a_out_err)
  );

  mux_tree_pipe #(.N_CH(5), .W(8)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .sel(b_sel),
    .scan_en(b_scan_en), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ch(b_out_ch), .out_err(b_out_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) a_in_data[k*8 +: 8] = 8'(8'hA0 + k);
    for (int k = 0; k < 5; k++) b_in_data[k*8 +: 8] = 8'(8'h50 + k);
    a_in_valid = 1'b1; a_sel = 3'd5; a_scan_en = 1'b1;
    b_in_valid = 1'b1; b_sel = 3'd6; b_scan_en = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({a_out_data, a_out_valid, a_out_ch, a_out_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_a: got %h expected 0", {a_out_data, a_out_valid, a_out_ch, a_out_err});
    end
    n_tests++;
    if ({b_out_data, b_out_valid, b_out_ch, b_out_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_b: got %h expected 0", {b_out_data, b_out_valid, b_out_ch, b_out_err});
    end
    rst = 1'b0;
    a_in_valid = 1'b0; a_scan_en = 1'b0;
    b_in_valid = 1'b0; b_scan_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d: got a=%b b=%b expected 0", c, a_out_valid, b_out_valid);
      end
    end
  endtask

  task automatic test_ext_sel();
    a_sel = 3'd5; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; a_sel = 3'd0;
    tick();
    n_tests++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_early: got valid=%b expected 0", a_out_valid);
    end
    tick();
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_data !== 8'hA5 || a_out_ch !== 3'd5 || a_out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_sel5: got v=%b d=%h ch=%0d e=%b expected v=1 d=a5 ch=5 e=0",
               a_out_valid, a_out_data, a_out_ch, a_out_err);
    end
    for (int c = 0; c < 10; c++) begin
      a_in_valid = (c < 8);
      a_sel = 3'(c);
      tick();
      if (c >= 2) begin
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'(8'hA0 + c - 2) || a_out_ch !== 3'(c - 2)) begin
          n_fail++;
          $display("FAIL ext_sweep k=%0d: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d",
                   c - 2, a_out_valid, a_out_data, a_out_ch, 8'(8'hA0 + c - 2), c - 2);
        end
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_scan();
    int ch1 [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    int vld2 [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int ch2 [10] = '{0, 1, 2, 0, 0, 3, 4, 5, 6, 7};
    a_sel = 3'd5;
    for (int c = 0; c < 12; c++) begin
      a_scan_en = (c < 10);
      a_in_valid = (c < 10);
      tick();
      if (c >= 2) begin
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_ch !== 3'(ch1[c-2]) || a_out_data !== 8'(8'hA0 + ch1[c-2])) begin
          n_fail++;
          $display("FAIL scan_run k=%0d: got v=%b ch=%0d d=%h expected v=1 ch=%0d",
                   c - 2, a_out_valid, a_out_ch, a_out_data, ch1[c-2]);
        end
      end
    end
    for (int c = 0; c < 12; c++) begin
      a_scan_en = (c < 10);
      a_in_valid = (c < 10) ? (vld2[c] != 0) : 1'b0;
      tick();
      if (c >= 2) begin
        n_tests++;
        if (a_out_valid !== (vld2[c-2] != 0) ||
            (vld2[c-2] != 0 && (a_out_ch !== 3'(ch2[c-2]) || a_out_data !== 8'(8'hA0 + ch2[c-2])))) begin
          n_fail++;
          $display("FAIL scan_gap k=%0d: got v=%b ch=%0d d=%h expected v=%0d ch=%0d",
                   c - 2, a_out_valid, a_out_ch, a_out_data, vld2[c-2], ch2[c-2]);
        end
      end
    end
  endtask

  task automatic test_np2();
    int scn [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int sl  [11] = '{4, 6, 5, 7, 2, 2, 2, 2, 2, 2, 2};
    int ch  [11] = '{4, 6, 5, 7, 0, 1, 2, 3, 4, 0, 1};
    int er  [11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    int dat [11] = '{'h54, 0, 0, 0, 'h50, 'h51, 'h52, 'h53, 'h54, 'h50, 'h51};
    for (int c = 0; c < 13; c++) begin
      b_in_valid = (c < 11);
      b_scan_en = (c < 11) ? (scn[c] != 0) : 1'b0;
      b_sel = (c < 11) ? 3'(sl[c]) : 3'd0;
      tick();
      if (c >= 2) begin
        n_tests++;
        if (b_out_valid !== 1'b1 || b_out_ch !== 3'(ch[c-2]) ||
            b_out_err !== (er[c-2] != 0) || b_out_data !== 8'(dat[c-2])) begin
          n_fail++;
          $display("FAIL np2 k=%0d: got v=%b ch=%0d e=%b d=%h expected v=1 ch=%0d e=%0d d=%h",
                   c - 2, b_out_valid, b_out_ch, b_out_err, b_out_data, ch[c-2], er[c-2], dat[c-2]);
        end
      end
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_scan_en = 1'b0;
    a_in_valid = 1'b1;
    a_sel = 3'd1; tick();
    a_sel = 3'd2; tick();
    a_sel = 3'd3; tick();
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_ch !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_prefill: got v=%b ch=%0d expected v=1 ch=1", a_out_valid, a_out_ch);
    end
    rst = 1'b1;
    #2;
    n_tests++;
    if ({a_out_data, a_out_valid, a_out_ch, a_out_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL mid_async: got %h expected 0", {a_out_data, a_out_valid, a_out_ch, a_out_err});
    end
    rst = 1'b0;
    a_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (a_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_stale c=%0d: got v=%b expected 0", c, a_out_valid);
      end
    end
    a_sel = 3'd6; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    n_tests++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_early: got v=%b expected 0", a_out_valid);
    end
    tick();
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_data !== 8'hA6 || a_out_ch !== 3'd6) begin
      n_fail++;
      $display("FAIL mid_next: got v=%b d=%h ch=%0d expected v=1 d=a6 ch=6",
               a_out_valid, a_out_data, a_out_ch);
    end
  endtask

  task automatic test_mode_switch();
    int ch [16] = '{3, 3, 3, 3, 0, 1, 2, 3, 3, 3, 3, 3, 0, 1, 2, 3};
    a_sel = 3'd3;
    for (int c = 0; c < 18; c++) begin
      a_in_valid = (c < 16);
      a_scan_en = (c < 16) ? (((c / 4) % 2) == 1) : 1'b0;
      tick();
      if (c >= 2) begin
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_ch !== 3'(ch[c-2]) || a_out_data !== 8'(8'hA0 + ch[c-2])) begin
          n_fail++;
          $display("FAIL mode k=%0d: got v=%b ch=%0d d=%h expected v=1 ch=%0d",
                   c - 2, a_out_valid, a_out_ch, a_out_data, ch[c-2]);
        end
      end
    end
    a_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ext_sel();
    test_scan();
    test_np2();
    test_reset_mid();
    test_mode_switch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
